// File: rtl/lmsm_sequencer_pkg.sv
// ISA constants and field helpers shared by the decode-stage blocks.
// Opcodes, NOP encoding, sequencer state type.
package lmsm_sequencer_pkg;

   localparam int XLEN  = 16;
   localparam int NREG  = 8;
   localparam int OFF_W = 6;
   localparam int IDX_W = 3;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_ADI = 4'b0001;
   localparam logic [3:0] OP_NDU = 4'b0010;
   localparam logic [3:0] OP_LHI = 4'b0011;
   localparam logic [3:0] OP_LW  = 4'b0100;
   localparam logic [3:0] OP_SW  = 4'b0101;
   localparam logic [3:0] OP_LM  = 4'b0110;
   localparam logic [3:0] OP_SM  = 4'b0111;
   localparam logic [3:0] OP_JAL = 4'b1000;
   localparam logic [3:0] OP_JLR = 4'b1001;
   localparam logic [3:0] OP_BEQ = 4'b1100;

   localparam logic [XLEN-1:0] NOP_IR = 16'hF000;

   typedef enum logic {
      S_IDLE,
      S_SEQ
   } state_t;

   function automatic logic [3:0] f_op(
      input logic [XLEN-1:0] ir
   );
      return ir[15:12];
   endfunction

   function automatic logic [2:0] f_ra(
      input logic [XLEN-1:0] ir
   );
      return ir[11:9];
   endfunction

   function automatic logic [2:0] f_rb(
      input logic [XLEN-1:0] ir
   );
      return ir[8:6];
   endfunction

   function automatic logic [2:0] f_rc(
      input logic [XLEN-1:0] ir
   );
      return ir[5:3];
   endfunction

   function automatic logic [5:0] f_imm6(
      input logic [XLEN-1:0] ir
   );
      return ir[5:0];
   endfunction

   function automatic logic [7:0] f_imm8(
      input logic [XLEN-1:0] ir
   );
      return ir[7:0];
   endfunction

   function automatic logic [NREG-1:0] onehot(
      input logic [IDX_W-1:0] idx
   );
      return NREG'(1) << idx;
   endfunction

   // Number of set mask bits strictly below idx.
   function automatic logic [IDX_W-1:0] popcount_below(
      input logic [NREG-1:0]  m,
      input logic [IDX_W-1:0] idx
   );
      logic [IDX_W-1:0] c;
      c = '0;
      for (int i = 0; i < NREG; i++) begin
         if (i < int'(idx) && m[i]) begin
            c = c + IDX_W'(1);
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/lmsm_sequencer_mask_pick.sv
// Picks the next register of an LM/SM mask, lowest index first,
// holding a deferred base register back until it is the only bit left.
module lmsm_sequencer_mask_pick
   import lmsm_sequencer_pkg::*;
(
   input  logic [NREG-1:0]  mask,
   input  logic             defer_en,
   input  logic [IDX_W-1:0] defer_idx,
   output logic [IDX_W-1:0] idx,
   output logic [IDX_W-1:0] rank,
   output logic             is_last
);

   logic [NREG-1:0] defer_bit;
   logic [NREG-1:0] m_nd;
   logic [NREG-1:0] m_eff;

   always_comb begin
      defer_bit = defer_en ? onehot(defer_idx) : '0;
      m_nd      = mask & ~defer_bit;
      m_eff     = (m_nd != '0) ? m_nd : mask;
      idx       = '0;
      for (int i = NREG - 1; i >= 0; i--) begin
         if (m_eff[i]) begin
            idx = IDX_W'(i);
         end
      end
      rank    = popcount_below(mask, idx);
      is_last = (mask & ~onehot(idx)) == '0;
   end

endmodule

// File: rtl/lmsm_sequencer.sv
// Decode-stage LM/SM sequencer: expands multi-register transfers
// into LW/SW micro-ops behind a registered valid/ready output.
module lmsm_sequencer
   import lmsm_sequencer_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] in_ir,
   input  logic [XLEN-1:0] in_pc,
   input  logic            in_valid,
   output logic            in_ready,
   output logic [XLEN-1:0] out_ir,
   output logic [XLEN-1:0] out_pc,
   output logic            out_valid,
   input  logic            out_ready,
   input  logic            flush,
   output logic            pc_hold,
   output logic            first_uop,
   output logic            last_uop
);

   state_t state, state_nx;

   logic [IDX_W-1:0] ra_q;
   logic [IDX_W-1:0] offset_q;
   logic [IDX_W-1:0] defer_off_q;
   logic             lm_q;
   logic [XLEN-1:0]  pc_q;
   logic [NREG-1:0]  mask_q;

   logic idle, load, accept;
   logic in_lm, in_multi;

   logic [NREG-1:0]  pk_mask;
   logic             pk_defer;
   logic [IDX_W-1:0] pk_didx;
   logic [IDX_W-1:0] pk_idx;
   logic [IDX_W-1:0] pk_rank;
   logic             pk_last;

   logic             uop_lm;
   logic [IDX_W-1:0] uop_ra;
   logic [IDX_W-1:0] uop_off;
   logic [XLEN-1:0]  uop_ir;

   assign idle     = state == S_IDLE;
   assign load     = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign in_lm    = f_op(in_ir) == OP_LM;
   assign in_multi = in_lm || f_op(in_ir) == OP_SM;

   lmsm_sequencer_mask_pick u_pick (
      .mask      (pk_mask),
      .defer_en  (pk_defer),
      .defer_idx (pk_didx),
      .idx       (pk_idx),
      .rank      (pk_rank),
      .is_last   (pk_last)
   );

   // IDLE picks from the incoming IR, SEQ from the latched copy.
   always_comb begin
      pk_mask  = mask_q;
      pk_defer = lm_q;
      pk_didx  = ra_q;
      uop_lm   = lm_q;
      uop_ra   = ra_q;
      uop_off  = offset_q + pk_rank;
      if (idle) begin
         pk_mask  = f_imm8(in_ir);
         pk_defer = in_lm;
         pk_didx  = f_ra(in_ir);
         uop_lm   = in_lm;
         uop_ra   = f_ra(in_ir);
         uop_off  = pk_rank;
      end else if (lm_q && pk_idx == ra_q) begin
         uop_off = defer_off_q;
      end
      uop_ir = {uop_lm ? OP_LW : OP_SW, pk_idx, uop_ra,
                OFF_W'(uop_off)};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      if (flush) begin
         state_nx = S_IDLE;
      end else begin
         unique case (state)
            S_IDLE:
               if (accept && in_multi && !pk_last) begin
                  state_nx = S_SEQ;
               end
            S_SEQ:
               if (load && pk_last) begin
                  state_nx = S_IDLE;
               end
         endcase
      end
   end

   // pc_hold drops while the final micro-op is being loaded.
   always_comb begin
      in_ready = idle && load && !flush;
      pc_hold  = (!idle && !(load && pk_last)) ||
                 (accept && in_multi && !pk_last);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid   <= 1'b0;
         out_ir      <= NOP_IR;
         out_pc      <= '0;
         first_uop   <= 1'b0;
         last_uop    <= 1'b0;
         ra_q        <= '0;
         lm_q        <= 1'b0;
         pc_q        <= '0;
         mask_q      <= '0;
         offset_q    <= '0;
         defer_off_q <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
         first_uop <= 1'b0;
         last_uop  <= 1'b0;
         mask_q    <= '0;
         offset_q  <= '0;
      end else if (load) begin
         if (!idle) begin
            out_valid <= 1'b1;
            out_ir    <= uop_ir;
            out_pc    <= pc_q;
            first_uop <= 1'b0;
            last_uop  <= pk_last;
            mask_q    <= mask_q & ~onehot(pk_idx);
            offset_q  <= offset_q + IDX_W'(1);
         end else if (accept) begin
            out_valid <= 1'b1;
            out_pc    <= in_pc;
            first_uop <= in_multi;
            last_uop  <= in_multi ? pk_last : 1'b1;
            if (!in_multi) begin
               out_ir <= in_ir;
            end else if (f_imm8(in_ir) == '0) begin
               out_ir <= NOP_IR;
            end else begin
               out_ir <= uop_ir;
            end
            if (in_multi) begin
               ra_q        <= f_ra(in_ir);
               lm_q        <= in_lm;
               pc_q        <= in_pc;
               defer_off_q <= popcount_below(f_imm8(in_ir),
                                             f_ra(in_ir));
               mask_q      <= pk_last ? '0 :
                              f_imm8(in_ir) & ~onehot(pk_idx);
               offset_q    <= IDX_W'(1);
            end
         end else begin
            out_valid <= 1'b0;
            first_uop <= 1'b0;
            last_uop  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Bench for lmsm_sequencer: expansion model with per-cycle compare
// plus hand-computed micro-op encodings for the directed cases.
module tb_lmsm_sequencer;

   typedef struct packed {
      logic [15:0] ir;
      logic [15:0] pc;
      logic        first;
      logic        last;
   } exp_t;

   logic        clk;
   logic        reset;
   logic [15:0] in_ir;
   logic [15:0] in_pc;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] out_ir;
   logic [15:0] out_pc;
   logic        out_valid;
   logic        out_ready;
   logic        flush;
   logic        pc_hold;
   logic        first_uop;
   logic        last_uop;

   lmsm_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .in_ir     (in_ir),
      .in_pc     (in_pc),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_ir    (out_ir),
      .out_pc    (out_pc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .flush     (flush),
      .pc_hold   (pc_hold),
      .first_uop (first_uop),
      .last_uop  (last_uop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int hold_cnt = 0;
   int rdy_low  = 0;

   exp_t        q[$];
   exp_t        ex_q[$];
   logic [15:0] log_ir[$];
   logic [15:0] log_pc[$];
   logic [1:0]  log_fl[$];
   int          log_cyc[$];

   task automatic chk16(input string nm, input logic [15:0] a,
                        input logic [15:0] e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, a, e);
      end
   endtask

   task automatic chkb(input string nm, input logic a,
                       input logic e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", nm, a, e);
      end
   endtask

   task automatic chki(input string nm, input int a, input int e);
      n_chk++;
      if (a != e) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, a, e);
      end
   endtask

   // Spec-level expansion: ascending offsets by mask rank, LM base
   // register moved to the end when other bits are present.
   task automatic expand(input logic [15:0] ir, input logic [15:0] pc);
      logic [3:0]  op;
      logic [7:0]  m;
      logic [2:0]  ra;
      logic [15:0] lst[$];
      logic [15:0] u;
      logic [15:0] dfr_ir;
      logic        dfr;
      int          cnt;
      int          r;
      exp_t        e;
      ex_q.delete();
      op = ir[15:12];
      m  = ir[7:0];
      ra = ir[11:9];
      cnt = $countones(m);
      dfr_ir = 16'h0;
      if (op != 4'h6 && op != 4'h7) begin
         lst.push_back(ir);
      end else if (cnt == 0) begin
         lst.push_back(16'hF000);
      end else begin
         dfr = (op == 4'h6) && m[ra] && cnt > 1;
         r = 0;
         for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
               u = {(op == 4'h6) ? 4'h4 : 4'h5, 3'(i), ra, 6'(r)};
               if (dfr && i == int'(ra)) dfr_ir = u;
               else lst.push_back(u);
               r++;
            end
         end
         if (dfr) lst.push_back(dfr_ir);
      end
      foreach (lst[j]) begin
         e.ir    = lst[j];
         e.pc    = pc;
         e.first = (op == 4'h6 || op == 4'h7) && j == 0;
         e.last  = j == lst.size() - 1;
         ex_q.push_back(e);
      end
   endtask

   logic acc, ld, hexp;
   int   unl;

   always @(negedge clk) begin
      cyc++;
      if (reset) begin
         q.delete();
      end else begin
         acc = in_valid && in_ready;
         if (acc) expand(in_ir, in_pc);
         else ex_q.delete();
         unl = (q.size() > 0) ? q.size() - 1 : 0;
         chkb("out_valid", out_valid, q.size() != 0);
         if (out_valid && q.size() != 0) begin
            chk16("out_ir", out_ir, q[0].ir);
            chk16("out_pc", out_pc, q[0].pc);
            chkb("first_uop", first_uop, q[0].first);
            chkb("last_uop", last_uop, q[0].last);
         end
         if (!flush) begin
            ld = !out_valid || out_ready;
            chkb("in_ready", in_ready,
                 unl == 0 && (q.size() == 0 || out_ready));
            if (acc) hexp = ex_q.size() > 1;
            else if (ld) hexp = unl > 1;
            else hexp = unl > 0;
            chkb("pc_hold", pc_hold, hexp);
            if (!in_ready) rdy_low++;
         end
         if (pc_hold) hold_cnt++;
         if (flush) begin
            q.delete();
         end else begin
            if (out_valid && out_ready && q.size() != 0) begin
               log_ir.push_back(out_ir);
               log_pc.push_back(out_pc);
               log_fl.push_back({first_uop, last_uop});
               log_cyc.push_back(cyc);
               void'(q.pop_front());
            end
            foreach (ex_q[j]) q.push_back(ex_q[j]);
         end
      end
   end

   task automatic issue(input logic [15:0] ir, input logic [15:0] pc);
      int   n;
      logic got;
      n = 0;
      got = 1'b0;
      in_ir = ir;
      in_pc = pc;
      in_valid = 1'b1;
      while (!got && n < 50) begin
         @(negedge clk);
         got = in_ready;
         n++;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      chkb("issue_accept", got, 1'b1);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (q.size() != 0 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chki("wait_idle_qsize", q.size(), 0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chkb({tag, "_valid"}, out_valid, 1'b0);
      chk16({tag, "_ir"}, out_ir, 16'hF000);
      chk16({tag, "_pc"}, out_pc, 16'h0000);
      chkb({tag, "_hold"}, pc_hold, 1'b0);
      chkb({tag, "_first"}, first_uop, 1'b0);
      chkb({tag, "_last"}, last_uop, 1'b0);
   endtask

   int b;

   initial begin
      reset = 1'b1;
      in_valid = 1'b0;
      in_ir = 16'h0;
      in_pc = 16'h0;
      out_ready = 1'b1;
      flush = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk_reset_vals("rst");
      @(posedge clk);
      #1;
      reset = 1'b0;

      // LM R1, mask 0000_0101
      hold_cnt = 0;
      b = log_ir.size();
      issue(16'h6205, 16'h0010);
      wait_idle();
      chki("t1_count", log_ir.size() - b, 2);
      chk16("t1_u0", log_ir[b], 16'h4040);
      chk16("t1_u1", log_ir[b+1], 16'h4441);
      chk16("t1_pc", log_pc[b+1], 16'h0010);
      chki("t1_fl0", int'(log_fl[b]), 2);
      chki("t1_fl1", int'(log_fl[b+1]), 1);
      chki("t1_hold_cycles", hold_cnt, 1);

      // SM R3, mask FF
      rdy_low = 0;
      b = log_ir.size();
      issue(16'h76FF, 16'h0020);
      wait_idle();
      chki("t2_count", log_ir.size() - b, 8);
      chk16("t2_u0", log_ir[b], 16'h50C0);
      chk16("t2_u7", log_ir[b+7], 16'h5EC7);
      chki("t2_span", log_cyc[b+7] - log_cyc[b], 7);
      chki("t2_rdy_low", rdy_low, 7);

      // LM with base register inside the mask
      b = log_ir.size();
      issue(16'h6407, 16'h0030);
      wait_idle();
      chk16("t3a_u0", log_ir[b], 16'h4080);
      chk16("t3a_u1", log_ir[b+1], 16'h4281);
      chk16("t3a_u2", log_ir[b+2], 16'h4482);
      b = log_ir.size();
      issue(16'h6207, 16'h0032);
      wait_idle();
      chk16("t3b_u0", log_ir[b], 16'h4040);
      chk16("t3b_u1", log_ir[b+1], 16'h4442);
      chk16("t3b_u2", log_ir[b+2], 16'h4241);
      b = log_ir.size();
      issue(16'h6003, 16'h0034);
      wait_idle();
      chk16("t3c_u0", log_ir[b], 16'h4201);
      chk16("t3c_u1", log_ir[b+1], 16'h4000);

      // Empty mask, then ADD back-to-back; single-bit LM
      b = log_ir.size();
      issue(16'h6200, 16'h0040);
      issue(16'h0298, 16'h0042);
      wait_idle();
      chk16("t4_nop", log_ir[b], 16'hF000);
      chki("t4_nop_fl", int'(log_fl[b]), 3);
      chk16("t4_add", log_ir[b+1], 16'h0298);
      chki("t4_add_fl", int'(log_fl[b+1]), 1);
      chk16("t4_add_pc", log_pc[b+1], 16'h0042);
      chki("t4_gap", log_cyc[b+1] - log_cyc[b], 1);
      b = log_ir.size();
      issue(16'h6608, 16'h0044);
      wait_idle();
      chk16("t4_single", log_ir[b], 16'h46C0);
      chki("t4_single_fl", int'(log_fl[b]), 3);

      // SM R4 mask 0F with a 3-cycle stall on the 2nd micro-op
      b = log_ir.size();
      issue(16'h780F, 16'h0050);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk16("t5_stall_ir", out_ir, 16'h5301);
         chkb("t5_stall_hold", pc_hold, 1'b1);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      wait_idle();
      chki("t5_count", log_ir.size() - b, 4);
      chk16("t5_u1", log_ir[b+1], 16'h5301);
      chk16("t5_u2", log_ir[b+2], 16'h5502);
      chk16("t5_u3", log_ir[b+3], 16'h5703);

      // Flush during the 3rd micro-op of LM R5 mask FF
      b = log_ir.size();
      issue(16'h6AFF, 16'h0060);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      @(negedge clk);
      chkb("t6_flush_valid", out_valid, 1'b0);
      chkb("t6_flush_hold", pc_hold, 1'b0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chkb("t6_flush_ready", in_ready, 1'b1);
      chki("t6_count", log_ir.size() - b, 2);
      @(posedge clk);
      #1;

      // Same, with reset instead of flush
      issue(16'h6AFF, 16'h0070);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk_reset_vals("t6_rst");
      @(posedge clk);
      #1;
      b = log_ir.size();
      issue(16'h0298, 16'h0080);
      wait_idle();
      chk16("t6_after", log_ir[b], 16'h0298);

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
